// File: rtl/nes_pad_reader.sv
// NES controller poller: latches the pad, shifts in eight buttons, and publishes them once per poll period.
// Define NES_PAD_DEBOUNCE_EN so that the buttons update only when two consecutive frames agree.
module nes_pad_reader #(
    parameter int TICK        = 300,
    parameter int POLL_CYCLES = 833333
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iData,
    output logic       oLatch,
    output logic       oClk,
    output logic [7:0] oButtons,
    output logic       oValid,
    output logic       oBusy
);

    localparam int PW = $clog2(POLL_CYCLES);
    localparam int HW = $clog2(2 * TICK);

    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
    localparam logic [HW-1:0] PH_LATCH  = HW'(2 * TICK - 1);
    localparam logic [HW-1:0] PH_BIT    = HW'(TICK - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LATCH = 3'd1;
    localparam logic [2:0] S_LOW   = 3'd2;
    localparam logic [2:0] S_HIGH  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [PW-1:0] poll_q, poll_d;
    logic [HW-1:0] phase_q, phase_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    btn_q, btn_d;
    logic [1:0]    sync_q;
    logic          latch_q, clk_q, valid_q, busy_q;

`ifdef NES_PAD_DEBOUNCE_EN
    logic [7:0]    prev_q, prev_d;
`endif

    always_comb begin
        state_d = state_q;
        phase_d = phase_q + HW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        btn_d   = btn_q;
        poll_d  = (poll_q == POLL_LAST) ? '0 : poll_q + PW'(1);
`ifdef NES_PAD_DEBOUNCE_EN
        prev_d  = prev_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                phase_d = '0;
                if (poll_q == POLL_LAST) begin
                    state_d = S_LATCH;
                    bit_d   = '0;
                end
            end
            S_LATCH: begin
                if (phase_q == PH_LATCH) begin
                    state_d = S_LOW;
                    phase_d = '0;
                end
            end
            S_LOW: begin
                if (phase_q == PH_BIT) begin
                    shift_d[bit_q] = ~sync_q[1];
                    state_d        = S_HIGH;
                    phase_d        = '0;
                end
            end
            S_HIGH: begin
                if (phase_q == PH_BIT) begin
                    phase_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_DONE;
                        // Buttons land together with the oValid pulse
`ifdef NES_PAD_DEBOUNCE_EN
                        if (shift_q == prev_q) btn_d = shift_q;
                        prev_d = shift_q;
`else
                        btn_d = shift_q;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        state_d = S_LOW;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                phase_d = '0;
            end
            default: begin
                state_d = S_IDLE;
                phase_d = '0;
            end
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= S_IDLE;
            poll_q  <= '0;
            phase_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            btn_q   <= '0;
            sync_q  <= 2'b11;
            latch_q <= 1'b0;
            clk_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            poll_q  <= poll_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            btn_q   <= btn_d;
            sync_q  <= {sync_q[0], iData};
            // Pin drivers are registered from the next state so they never glitch
            latch_q <= (state_d == S_LATCH);
            clk_q   <= (state_d == S_HIGH);
            valid_q <= (state_d == S_DONE);
            busy_q  <= (state_d != S_IDLE);
        end
    end

`ifdef NES_PAD_DEBOUNCE_EN
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) prev_q <= '0;
        else      prev_q <= prev_d;
    end
`endif

    assign oLatch   = latch_q;
    assign oClk     = clk_q;
    assign oButtons = btn_q;
    assign oValid   = valid_q;
    assign oBusy    = busy_q;

endmodule

// File: tb/tb_nes_pad_reader.sv
// Bench for nes_pad_reader with TICK=2, POLL_CYCLES=50 and a behavioural NES pad.
// Works with or without NES_PAD_DEBOUNCE_EN defined.
module tb_nes_pad_reader;

    localparam int TICK = 2;
    localparam int POLL = 50;

    logic       iCLK = 1'b0;
    logic       iRST;
    logic       iData;
    logic       oLatch;
    logic       oClk;
    logic [7:0] oButtons;
    logic       oValid;
    logic       oBusy;

    nes_pad_reader #(.TICK(TICK), .POLL_CYCLES(POLL)) dut (
        .iCLK(iCLK), .iRST(iRST), .iData(iData),
        .oLatch(oLatch), .oClk(oClk), .oButtons(oButtons),
        .oValid(oValid), .oBusy(oBusy)
    );

    always #5 iCLK = ~iCLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Pad model state
    logic [7:0] pressed = 8'h00;
    int         ptr = 8;
    logic       pad_clk_prev = 1'b0;

    // Monitor state
    logic       in_frame = 1'b0;
    logic [7:0] btn_prev = 8'h00;

    // Reference model state
    logic [7:0] m_btn = 8'h00;
`ifdef NES_PAD_DEBOUNCE_EN
    logic [7:0] m_prev = 8'h00;
`endif

    typedef struct {
        logic [7:0] p;
        logic [7:0] exp_nodb;
        logic [7:0] exp_db;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] p);
`ifdef NES_PAD_DEBOUNCE_EN
        if (p == m_prev) m_btn = p;
        m_prev = p;
`else
        m_btn = p;
`endif
        return m_btn;
    endfunction

    task automatic step();
        @(posedge iCLK);
        #1;
        cyc++;
        if (oLatch) ptr = 0;
        else if (oClk && !pad_clk_prev && ptr < 8) ptr++;
        pad_clk_prev = oClk;
        iData = (ptr < 8) ? ~pressed[ptr] : 1'b1;
        chk("latch_clk_excl", {31'd0, oLatch & oClk}, 32'd0);
        if (oLatch && !in_frame) in_frame = 1'b1;
        chk("busy", {31'd0, oBusy}, {31'd0, in_frame});
        if (!oValid && !iRST) chk("btn_hold", {24'd0, oButtons}, {24'd0, btn_prev});
        btn_prev = oButtons;
        if (oValid) in_frame = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] p, output int t_lat, output int t_val,
                             output int n_lat, output int n_clk, output int bad_hi);
        int hi;
        pressed = p;
        t_lat = -1; t_val = -1; n_lat = 0; n_clk = 0; bad_hi = 0; hi = 0;
        for (int i = 0; i < 200 && t_val < 0; i++) begin
            step();
            if (oLatch) begin
                n_lat++;
                if (t_lat < 0) t_lat = cyc;
            end
            if (oClk) begin
                hi++;
                if (hi == 1) n_clk++;
            end else begin
                if (hi != 0 && hi != TICK) bad_hi++;
                hi = 0;
            end
            if (oValid) t_val = cyc;
        end
        if (t_val < 0) chk("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic frame_shape(input int t_lat, input int t_val, input int n_lat,
                               input int n_clk, input int bad_hi);
        chk("latch_len", n_lat, 2 * TICK);
        chk("clk_pulses", n_clk, 8);
        chk("clk_high_len", bad_hi, 0);
        chk("frame_len", t_val - t_lat, 18 * TICK);
    endtask

    vec_t tbl[10];

    initial begin
        int t_lat, t_val, n_lat, n_clk, bad_hi, last_val, r, hr;
        logic [7:0] exp, p, last_p;

        tbl[0] = '{8'h00, 8'h00, 8'h00};
        tbl[1] = '{8'h81, 8'h81, 8'h00};
        tbl[2] = '{8'h81, 8'h81, 8'h81};
        tbl[3] = '{8'h02, 8'h02, 8'h81};
        tbl[4] = '{8'h81, 8'h81, 8'h81};
        tbl[5] = '{8'h02, 8'h02, 8'h81};
        tbl[6] = '{8'h00, 8'h00, 8'h81};
        tbl[7] = '{8'h00, 8'h00, 8'h00};
        tbl[8] = '{8'hFF, 8'hFF, 8'h00};
        tbl[9] = '{8'hFF, 8'hFF, 8'hFF};

        iRST = 1'b1;
        iData = 1'b1;
        repeat (3) @(posedge iCLK);
        #1;
        chk("rst_latch", {31'd0, oLatch}, 32'd0);
        chk("rst_clk", {31'd0, oClk}, 32'd0);
        chk("rst_valid", {31'd0, oValid}, 32'd0);
        chk("rst_busy", {31'd0, oBusy}, 32'd0);
        chk("rst_buttons", {24'd0, oButtons}, 32'd0);

        @(posedge iCLK);
        #1;
        iRST = 1'b0;
        cyc = 0;

        last_val = 0;
        for (int k = 0; k < 10; k++) begin
            run_frame(tbl[k].p, t_lat, t_val, n_lat, n_clk, bad_hi);
            frame_shape(t_lat, t_val, n_lat, n_clk, bad_hi);
            exp = model(tbl[k].p);
`ifdef NES_PAD_DEBOUNCE_EN
            chk("tbl_buttons", {24'd0, oButtons}, {24'd0, tbl[k].exp_db});
`else
            chk("tbl_buttons", {24'd0, oButtons}, {24'd0, tbl[k].exp_nodb});
`endif
            chk("tbl_model", {24'd0, oButtons}, {24'd0, exp});
            if (k == 0) begin
                chk("first_latch_cycle", t_lat, POLL);
                chk("first_valid_cycle", t_val, POLL + 18 * TICK);
            end else begin
                chk("valid_spacing", t_val - last_val, POLL);
            end
            last_val = t_val;
        end

        // Reset during the 4th shift clock pulse
        pressed = 8'h5A;
        r = 0; hr = 0;
        for (int i = 0; i < 200 && r < 4; i++) begin
            step();
            if (oClk) hr++;
            else hr = 0;
            if (oClk && hr == 1) r++;
        end
        chk("rst4_found", r, 4);
        iRST = 1'b1;
        #1;
        chk("abort_latch", {31'd0, oLatch}, 32'd0);
        chk("abort_clk", {31'd0, oClk}, 32'd0);
        chk("abort_valid", {31'd0, oValid}, 32'd0);
        chk("abort_busy", {31'd0, oBusy}, 32'd0);
        chk("abort_buttons", {24'd0, oButtons}, 32'd0);
        in_frame = 1'b0;
        btn_prev = 8'h00;
        m_btn = 8'h00;
`ifdef NES_PAD_DEBOUNCE_EN
        m_prev = 8'h00;
`endif
        repeat (2) begin
            step();
            chk("rst_hold_valid", {31'd0, oValid}, 32'd0);
        end
        iRST = 1'b0;
        cyc = 0;

        last_p = 8'h81;
        for (int k = 0; k < 14; k++) begin
            p = ($urandom_range(0, 1) == 1) ? last_p : 8'($urandom);
            run_frame(p, t_lat, t_val, n_lat, n_clk, bad_hi);
            frame_shape(t_lat, t_val, n_lat, n_clk, bad_hi);
            exp = model(p);
            chk("rand_buttons", {24'd0, oButtons}, {24'd0, exp});
            if (k == 0) chk("post_rst_latch", t_lat, POLL);
            else chk("rand_valid_spacing", t_val - last_val, POLL);
            last_val = t_val;
            last_p = p;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
